// File: rtl/watchdog_pkg.sv
// Shared types and defaults for the bus watchdog timer.
// The optional synthetic error-response drain is enabled with WDT_ERR_RESP_EN.
package watchdog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_TRIPPED = 2'd3
  } wdt_state_e;

  localparam int unsigned WDT_MAX_OUTSTANDING_DEF = 32'd4;
  localparam int unsigned WDT_TIMEOUT_DEF         = 32'd1000;
  // Wide enough for the largest supported MAX_OUTSTANDING (15).
  localparam int unsigned CNT_W                   = 32'd4;

endpackage

// File: rtl/wdt_outstanding_ctr.sv
// Saturating up/down counter of in-flight bus transactions.
// Requests add one; real and synthetic responses each subtract one, floored at zero.
module wdt_outstanding_ctr
  import watchdog_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = WDT_MAX_OUTSTANDING_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_flush_dec,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_next,
  output logic             o_sat_req
);

  localparam logic [CNT_W:0] LP_MAX  = MAX_OUTSTANDING[CNT_W:0];
  localparam logic [CNT_W:0] LP_ZERO = {(CNT_W+1){1'b0}};

  logic [CNT_W-1:0] r_count;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W:0]   w_sub;
  logic [CNT_W:0]   w_diff;
  logic [CNT_W:0]   w_next;

  always_comb begin
    w_sum  = {1'b0, r_count} + {{CNT_W{1'b0}}, i_inc};
    w_sub  = {{CNT_W{1'b0}}, i_dec} + {{CNT_W{1'b0}}, i_flush_dec};
    w_diff = w_sum - w_sub;
    if (i_clr) begin
      w_next = LP_ZERO;
    end else if (w_sum <= w_sub) begin
      w_next = LP_ZERO;
    end else if (w_diff > LP_MAX) begin
      w_next = LP_MAX;
    end else begin
      w_next = w_diff;
    end
  end

  // A request that cannot be absorbed because the count is already full.
  always_comb begin
    if (i_inc && !i_dec && !i_flush_dec && ({1'b0, r_count} == LP_MAX)) begin
      o_sat_req = 1'b1;
    end else begin
      o_sat_req = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_count <= w_next[CNT_W-1:0];
    end
  end

  assign o_count      = r_count;
  assign o_count_next = w_next[CNT_W-1:0];

endmodule

// File: rtl/bus_watchdog_timer.sv
// Bus watchdog: times how long outstanding transactions go unanswered and trips on timeout.
// Define WDT_ERR_RESP_EN to drain outstanding transactions with synthetic error responses on trip.
module bus_watchdog_timer
  import watchdog_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = WDT_MAX_OUTSTANDING_DEF,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] timeout_value_i,
  input  logic                  bus_req_i,
  input  logic                  bus_rsp_i,
  input  logic                  status_clr_i,
  output logic                  timeout_status_o,
  output logic                  overflow_o,
  output logic                  irq_o
`ifdef WDT_ERR_RESP_EN
  ,
  output logic                  err_rsp_valid_o
`endif
);

`ifdef WDT_ERR_RESP_EN
  localparam wdt_state_e LP_TRIP_STATE = ST_FLUSH;
`else
  localparam wdt_state_e LP_TRIP_STATE = ST_TRIPPED;
`endif

  localparam logic [CNT_W-1:0]      LP_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] LP_TMR_ZERO = {DATA_WIDTH{1'b0}};

  wdt_state_e            r_state;
  wdt_state_e            w_state_next;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] w_cnt_next;
  logic [DATA_WIDTH:0]   w_cnt_inc;
  logic [DATA_WIDTH:0]   w_tmo_eff;
  logic                  r_status;
  logic                  w_status_next;
  logic                  r_ovf;
  logic                  w_ovf_next;
  logic                  r_irq;
  logic                  w_irq_next;
  logic [CNT_W-1:0]      w_out_cnt;
  logic [CNT_W-1:0]      w_out_next;
  logic                  w_sat_req;
  logic                  w_ctr_clr;
  logic                  w_flush_dec;

  assign w_ctr_clr = (r_state == ST_TRIPPED) && status_clr_i;

  wdt_outstanding_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_ctr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_clr       (w_ctr_clr),
    .i_inc       (bus_req_i),
    .i_dec       (bus_rsp_i),
    .i_flush_dec (w_flush_dec),
    .o_count     (w_out_cnt),
    .o_count_next(w_out_next),
    .o_sat_req   (w_sat_req)
  );

  // A programmed timeout of zero is treated as one cycle.
  always_comb begin
    w_cnt_inc = {1'b0, r_cnt} + {{DATA_WIDTH{1'b0}}, 1'b1};
    if (timeout_value_i == LP_TMR_ZERO) begin
      w_tmo_eff = {{DATA_WIDTH{1'b0}}, 1'b1};
    end else begin
      w_tmo_eff = {1'b0, timeout_value_i};
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_status_next = r_status;
    w_irq_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = LP_TMR_ZERO;
        if (enable_i && (w_out_next != LP_CNT_ZERO)) begin
          w_state_next = ST_ARMED;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // A response in the would-be trip cycle takes priority over the timeout.
        if (!enable_i || (w_out_next == LP_CNT_ZERO)) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = LP_TMR_ZERO;
        end else if (bus_rsp_i) begin
          w_cnt_next = LP_TMR_ZERO;
        end else if (w_cnt_inc >= w_tmo_eff) begin
          w_state_next  = LP_TRIP_STATE;
          w_cnt_next    = LP_TMR_ZERO;
          w_status_next = 1'b1;
          w_irq_next    = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc[DATA_WIDTH-1:0];
        end
      end
      ST_FLUSH: begin
        w_cnt_next = LP_TMR_ZERO;
        if (w_out_next == LP_CNT_ZERO) begin
          w_state_next = ST_TRIPPED;
        end else begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_TRIPPED: begin
        w_cnt_next = LP_TMR_ZERO;
        if (status_clr_i) begin
          w_status_next = 1'b0;
          w_state_next  = ST_IDLE;
        end else begin
          w_state_next = ST_TRIPPED;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = LP_TMR_ZERO;
      end
    endcase
  end

  // Clearing is ignored while draining; outside FLUSH a clear beats a new overflow.
  always_comb begin
    if (status_clr_i && (r_state != ST_FLUSH)) begin
      w_ovf_next = 1'b0;
    end else if (w_sat_req) begin
      w_ovf_next = 1'b1;
    end else begin
      w_ovf_next = r_ovf;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {DATA_WIDTH{1'b0}};
      r_status <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_status <= w_status_next;
      r_ovf    <= w_ovf_next;
      r_irq    <= w_irq_next;
    end
  end

`ifdef WDT_ERR_RESP_EN
  logic r_err;

  assign w_flush_dec = (r_state == ST_FLUSH) && (w_out_cnt != LP_CNT_ZERO);

  // Registered so the pulse lines up with each FLUSH cycle that retires a transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_state_next == ST_FLUSH) && (w_out_next != LP_CNT_ZERO);
    end
  end

  assign err_rsp_valid_o = r_err;
`else
  assign w_flush_dec = 1'b0;
`endif

  assign timeout_status_o = r_status;
  assign overflow_o       = r_ovf;
  assign irq_o            = r_irq;

endmodule

// File: tb/tb_bus_watchdog_timer.sv
// Directed self-checking bench for bus_watchdog_timer (both with and without WDT_ERR_RESP_EN).
module tb_bus_watchdog_timer;
  import watchdog_pkg::*;

  localparam int unsigned DW = 32;
`ifdef WDT_ERR_RESP_EN
  localparam bit         FLUSH_EN  = 1'b1;
  localparam wdt_state_e EXP_TRIP  = ST_FLUSH;
`else
  localparam bit         FLUSH_EN  = 1'b0;
  localparam wdt_state_e EXP_TRIP  = ST_TRIPPED;
`endif

  logic          clk_i;
  logic          rst_ni;
  logic          enable_i;
  logic [DW-1:0] timeout_value_i;
  logic          bus_req_i;
  logic          bus_rsp_i;
  logic          status_clr_i;
  logic          timeout_status_o;
  logic          overflow_o;
  logic          irq_o;
`ifdef WDT_ERR_RESP_EN
  logic          err_rsp_valid_o;
`endif

  int n_checks;
  int n_err;

  bus_watchdog_timer #(
    .MAX_OUTSTANDING(4),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .enable_i        (enable_i),
    .timeout_value_i (timeout_value_i),
    .bus_req_i       (bus_req_i),
    .bus_rsp_i       (bus_rsp_i),
    .status_clr_i    (status_clr_i),
    .timeout_status_o(timeout_status_o),
    .overflow_o      (overflow_o),
    .irq_o           (irq_o)
`ifdef WDT_ERR_RESP_EN
    ,
    .err_rsp_valid_o (err_rsp_valid_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_status();
    status_clr_i = 1'b1;
    tick();
    status_clr_i = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_err           = 0;
    rst_ni          = 1'b0;
    enable_i        = 1'b0;
    timeout_value_i = 32'd5;
    bus_req_i       = 1'b0;
    bus_rsp_i       = 1'b0;
    status_clr_i    = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_status", timeout_status_o, 32'd0);
    chk("rst_ovf", overflow_o, 32'd0);
    chk("rst_irq", irq_o, 32'd0);
    chk("rst_state", dut.r_state, ST_IDLE);
    chk("rst_out", dut.w_out_cnt, 32'd0);
    chk("rst_cnt", dut.r_cnt, 32'd0);
`ifdef WDT_ERR_RESP_EN
    chk("rst_err", err_rsp_valid_o, 32'd0);
`endif
    rst_ni = 1'b1;
    tick();

    // Basic timeout, T=5, single request sampled at edge 0
    timeout_value_i = 32'd5;
    enable_i        = 1'b1;
    bus_req_i       = 1'b1;
    tick();
    bus_req_i = 1'b0;
    chk("t5_arm_state", dut.r_state, ST_ARMED);
    chk("t5_arm_out", dut.w_out_cnt, 32'd1);
    chk("t5_arm_cnt", dut.r_cnt, 32'd0);
    repeat (4) tick();
    chk("t5_e4_status", timeout_status_o, 32'd0);
    chk("t5_e4_irq", irq_o, 32'd0);
    chk("t5_e4_cnt", dut.r_cnt, 32'd4);
    tick();
    chk("t5_e5_status", timeout_status_o, 32'd1);
    chk("t5_e5_irq", irq_o, 32'd1);
    chk("t5_e5_state", dut.r_state, EXP_TRIP);
`ifdef WDT_ERR_RESP_EN
    chk("t5_e5_err", err_rsp_valid_o, 32'd1);
`endif
    tick();
    chk("t5_e6_irq", irq_o, 32'd0);
    chk("t5_e6_status", timeout_status_o, 32'd1);
    chk("t5_e6_state", dut.r_state, ST_TRIPPED);
    chk("t5_e6_out", dut.w_out_cnt, FLUSH_EN ? 32'd0 : 32'd1);
    repeat (3) tick();
    chk("t5_sticky", timeout_status_o, 32'd1);
    clear_status();
    chk("t5_clr_status", timeout_status_o, 32'd0);
    chk("t5_clr_state", dut.r_state, ST_IDLE);
    chk("t5_clr_out", dut.w_out_cnt, 32'd0);

    // Response in the trip cycle wins
    bus_req_i = 1'b1;
    tick();
    bus_req_i = 1'b0;
    repeat (4) tick();
    bus_rsp_i = 1'b1;
    tick();
    bus_rsp_i = 1'b0;
    chk("rsp_win_status", timeout_status_o, 32'd0);
    chk("rsp_win_irq", irq_o, 32'd0);
    chk("rsp_win_state", dut.r_state, ST_IDLE);
    chk("rsp_win_out", dut.w_out_cnt, 32'd0);
    tick();
    chk("rsp_win_status2", timeout_status_o, 32'd0);

    // Disable mid-count, then re-enable restarts from zero
    timeout_value_i = 32'd100;
    bus_req_i       = 1'b1;
    tick();
    bus_req_i = 1'b0;
    repeat (49) tick();
    chk("dis_cnt49", dut.r_cnt, 32'd49);
    chk("dis_armed", dut.r_state, ST_ARMED);
    enable_i = 1'b0;
    tick();
    chk("dis_state", dut.r_state, ST_IDLE);
    chk("dis_cnt", dut.r_cnt, 32'd0);
    chk("dis_out", dut.w_out_cnt, 32'd1);
    repeat (3) tick();
    enable_i = 1'b1;
    tick();
    chk("reen_state", dut.r_state, ST_ARMED);
    chk("reen_cnt0", dut.r_cnt, 32'd0);
    repeat (3) tick();
    chk("reen_cnt3", dut.r_cnt, 32'd3);
    enable_i  = 1'b0;
    bus_rsp_i = 1'b1;
    tick();
    bus_rsp_i = 1'b0;
    chk("dis_cleanup_out", dut.w_out_cnt, 32'd0);

    // Saturation at MAX_OUTSTANDING=4
    timeout_value_i = 32'd1000;
    enable_i        = 1'b1;
    bus_req_i       = 1'b1;
    repeat (4) tick();
    chk("sat_out4", dut.w_out_cnt, 32'd4);
    chk("sat_ovf_before", overflow_o, 32'd0);
    tick();
    bus_req_i = 1'b0;
    chk("sat_out_hold", dut.w_out_cnt, 32'd4);
    chk("sat_ovf", overflow_o, 32'd1);
    clear_status();
    chk("sat_clr_ovf", overflow_o, 32'd0);
    chk("sat_clr_out", dut.w_out_cnt, 32'd4);
    chk("sat_clr_state", dut.r_state, ST_ARMED);
    enable_i  = 1'b0;
    bus_rsp_i = 1'b1;
    repeat (4) tick();
    bus_rsp_i = 1'b0;
    chk("sat_drain_out", dut.w_out_cnt, 32'd0);
    chk("sat_drain_state", dut.r_state, ST_IDLE);

    // Timeout value 0 behaves as 1; requests in TRIPPED counted but do not re-arm
    timeout_value_i = 32'd0;
    enable_i        = 1'b1;
    bus_req_i       = 1'b1;
    tick();
    bus_req_i = 1'b0;
    tick();
    chk("t0_status", timeout_status_o, 32'd1);
    chk("t0_irq", irq_o, 32'd1);
    chk("t0_state", dut.r_state, EXP_TRIP);
    tick();
    chk("t0_tripped", dut.r_state, ST_TRIPPED);
    bus_req_i = 1'b1;
    tick();
    bus_req_i = 1'b0;
    chk("trp_req_out", dut.w_out_cnt, FLUSH_EN ? 32'd1 : 32'd2);
    chk("trp_req_state", dut.r_state, ST_TRIPPED);
    chk("trp_req_irq", irq_o, 32'd0);
    clear_status();
    chk("trp_clr_state", dut.r_state, ST_IDLE);
    chk("trp_clr_out", dut.w_out_cnt, 32'd0);
    chk("trp_clr_status", timeout_status_o, 32'd0);

`ifdef WDT_ERR_RESP_EN
    // Error-response drain, T=3, three outstanding
    timeout_value_i = 32'd3;
    bus_req_i       = 1'b1;
    repeat (3) tick();
    bus_req_i = 1'b0;
    chk("fl_pre_out", dut.w_out_cnt, 32'd3);
    chk("fl_pre_cnt", dut.r_cnt, 32'd2);
    tick();
    chk("fl_trip_irq", irq_o, 32'd1);
    chk("fl_trip_state", dut.r_state, ST_FLUSH);
    chk("fl_err1", err_rsp_valid_o, 32'd1);
    chk("fl_out3", dut.w_out_cnt, 32'd3);
    status_clr_i = 1'b1;
    tick();
    status_clr_i = 1'b0;
    chk("fl_err2", err_rsp_valid_o, 32'd1);
    chk("fl_out2", dut.w_out_cnt, 32'd2);
    chk("fl_clr_ignored", timeout_status_o, 32'd1);
    tick();
    chk("fl_err3", err_rsp_valid_o, 32'd1);
    chk("fl_out1", dut.w_out_cnt, 32'd1);
    tick();
    chk("fl_err_done", err_rsp_valid_o, 32'd0);
    chk("fl_done_state", dut.r_state, ST_TRIPPED);
    chk("fl_done_out", dut.w_out_cnt, 32'd0);
    clear_status();
    chk("fl_clr_state", dut.r_state, ST_IDLE);
    chk("fl_clr_status", timeout_status_o, 32'd0);

    // Reset asserted mid-flush
    timeout_value_i = 32'd2;
    bus_req_i       = 1'b1;
    repeat (2) tick();
    bus_req_i = 1'b0;
    tick();
    chk("rf_state", dut.r_state, ST_FLUSH);
    chk("rf_err", err_rsp_valid_o, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rf_rst_status", timeout_status_o, 32'd0);
    chk("rf_rst_ovf", overflow_o, 32'd0);
    chk("rf_rst_irq", irq_o, 32'd0);
    chk("rf_rst_err", err_rsp_valid_o, 32'd0);
    chk("rf_rst_state", dut.r_state, ST_IDLE);
    chk("rf_rst_out", dut.w_out_cnt, 32'd0);
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rf_post_irq", irq_o, 32'd0);
      chk("rf_post_err", err_rsp_valid_o, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_watchdog_timer.md
BUS_WATCHDOG_TIMER -- requirements
Module: bus_watchdog_timer

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, maximum tracked in-flight bus transactions (range 1..15).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the timeout value and the cycle counter.
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i  input  1  watchdog enable from the watchdog CSR block.
REQ-006 SHALL have port timeout_value_i  input  DATA_WIDTH  timeout in cycles, from the CSR block.
REQ-007 SHALL have port bus_req_i  input  1  one-cycle pulse: bus request accepted (valid&ready).
REQ-008 SHALL have port bus_rsp_i  input  1  one-cycle pulse: bus response received.
REQ-009 SHALL have port status_clr_i  input  1  clear of the sticky status, from the CSR block.
REQ-010 SHALL have port timeout_status_o  output  1  sticky timeout flag, consumed by the CSR status register.
REQ-011 SHALL have port overflow_o  output  1  sticky flag: request seen while outstanding count was saturated.
REQ-012 SHALL have port irq_o  output  1  one-cycle pulse on trip.
REQ-013 SHALL have port err_rsp_valid_o  output  1  synthetic error response to the core; present only under WDT_ERR_RESP_EN.

Function
REQ-014 SHALL keep a registered outstanding count: +1 on bus_req_i, -1 on bus_rsp_i, unchanged when both fire in one cycle, never below 0.
REQ-015 SHALL saturate the count at MAX_OUTSTANDING; a request arriving at saturation SHALL set overflow_o.
REQ-016 SHALL implement states IDLE, ARMED, FLUSH, TRIPPED.
REQ-017 IDLE->ARMED SHALL occur when enable_i=1 and the next outstanding count is nonzero; the counter is cleared to 0.
REQ-018 In ARMED, the counter SHALL increment by 1 per cycle; bus_rsp_i SHALL clear it to 0 in the same edge.
REQ-019 ARMED->IDLE SHALL occur when the outstanding count reaches 0 or enable_i=0; the counter is cleared.
REQ-020 Trip SHALL occur when counter_q+1 >= timeout_value_i with no bus_rsp_i that cycle; timeout_status_o SHALL be high exactly T edges after the edge that sampled the arming request.
REQ-021 timeout_value_i SHALL be compared live each cycle; a value of 0 SHALL behave as 1.
REQ-022 A bus_rsp_i in the trip cycle SHALL win: no trip, counter cleared.
REQ-023 On trip, irq_o SHALL pulse for exactly one cycle and timeout_status_o SHALL set.
REQ-024 Once set, timeout_status_o SHALL stay high until status_clr_i is seen in TRIPPED.
REQ-025 In TRIPPED, status_clr_i SHALL clear timeout_status_o, overflow_o, the counter and the outstanding count, then go to IDLE.
REQ-026 status_clr_i in any other state SHALL clear only overflow_o.
REQ-027 bus_req_i in FLUSH/TRIPPED SHALL be counted per REQ-014 but SHALL NOT re-arm.

Reset
REQ-028 During reset the state SHALL be IDLE and the counter and outstanding count 0.
REQ-029 During reset timeout_status_o, overflow_o, irq_o and err_rsp_valid_o SHALL be 0.
REQ-030 Reset asserted mid-count or mid-flush SHALL abort immediately; no pulse SHALL be emitted on release.

Configuration
REQ-031 With macro WDT_ERR_RESP_EN defined, the trip SHALL enter FLUSH.
REQ-032 In FLUSH, err_rsp_valid_o SHALL be high one cycle per outstanding transaction, decrementing the count once per cycle.
REQ-033 A real bus_rsp_i during FLUSH SHALL also decrement the count, floored at 0; FLUSH->TRIPPED SHALL occur when the count reaches 0.
REQ-034 status_clr_i during FLUSH SHALL be ignored.
REQ-035 Without WDT_ERR_RESP_EN, the trip SHALL go directly to TRIPPED, the FLUSH state SHALL be unreachable, and the err_rsp_valid_o port SHALL be absent.

Structure
REQ-036 The state enum, MAX_OUTSTANDING default and timeout default (1000) SHALL live in watchdog_pkg.
REQ-037 The outstanding up/down saturating counter SHALL be sub-module wdt_outstanding_ctr.

Verification
REQ-038 Timeout, T=5, enable=1, one bus_req_i at edge 0, no response -> timeout_status_o=1 after edge 5, irq_o high for one cycle.
REQ-039 Response in the trip cycle, T=5, bus_rsp_i in the cycle before edge 5 -> no trip, state IDLE, count 0.
REQ-040 Disable mid-count, T=100, req then enable_i=0 at cycle 50 -> IDLE, counter 0; re-enable -> fresh count from 0.
REQ-041 Saturation, MAX_OUTSTANDING=4, five reqs with no responses -> count 4, overflow_o=1; status_clr_i in ARMED clears overflow_o only.
REQ-042 Error-response drain, WDT_ERR_RESP_EN, T=3, 3 outstanding -> 3 consecutive err_rsp_valid_o pulses, then TRIPPED; status_clr_i -> IDLE, status 0.
REQ-043 Reset mid-flush, rst_ni low during FLUSH -> all outputs 0; no irq_o or err_rsp_valid_o after release.
